// File: rtl/seg7_scan_adder.sv
// seg7_scan_adder: registered WIDTH-bit adder driving a time-multiplexed hex 7-segment bank.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seg7_scan_adder #(
    parameter int unsigned  DIGITS      = 4,
    parameter int unsigned  REFRESH_DIV = 100000,
    localparam int unsigned WIDTH       = 4 * DIGITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              cin,
    input  logic              add_valid,
    output logic [WIDTH-1:0]  sum,
    output logic              cout,
    output logic              sum_valid,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] control
);

    localparam int unsigned PRESC_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              sum_valid_q, sum_valid_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [DIGITS-1:0] control_q, control_d;

    logic       slot_start;
    logic       presc_last;
    logic [3:0] nibble;
`ifdef LEADING_ZERO_BLANK_EN
    logic       upper_zero;
`endif

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        sum_d       = sum_q;
        cout_d      = cout_q;
        sum_valid_d = add_valid;
        if (add_valid) begin
            {cout_d, sum_d} = {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(cin);
        end
    end

    always_comb begin
        presc_last = (presc_q == PRESC_W'(REFRESH_DIV - 1));
        presc_d    = presc_last ? '0 : presc_q + PRESC_W'(1);
        idx_d      = idx_q;
        if (presc_last) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Display registers load from sum_q (pre-update value) at the slot's first edge.
    always_comb begin
        slot_start = (presc_q == '0);
        nibble     = '0;
`ifdef LEADING_ZERO_BLANK_EN
        upper_zero = 1'b0;
`endif
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                nibble = sum_q[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                upper_zero = ((sum_q >> (4 * i)) == '0);
`endif
            end
        end

        seg_d     = seg_q;
        dp_d      = dp_q;
        control_d = control_q;
        if (slot_start) begin
            seg_d = hex_seg(nibble);
`ifdef LEADING_ZERO_BLANK_EN
            if ((idx_q != '0) && upper_zero) begin
                seg_d = 7'h7F;
            end
`endif
            dp_d      = ~((idx_q == IDX_W'(DIGITS - 1)) && cout_q);
            control_d = ~(DIGITS'(1) << idx_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            sum_valid_q <= 1'b0;
            presc_q     <= '0;
            idx_q       <= '0;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
            control_q   <= '1;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            sum_valid_q <= sum_valid_d;
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            control_q   <= control_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign sum_valid = sum_valid_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign control   = control_q;

endmodule

// File: tb/tb_seg7_scan_adder.sv
// Self-checking bench for seg7_scan_adder (DIGITS=4, REFRESH_DIV=4) against a slot-level model.
module tb_seg7_scan_adder;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned RDIV   = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] a, b;
    logic        cin, add_valid;
    logic [15:0] sum;
    logic        cout, sum_valid;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  control;

    seg7_scan_adder #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .add_valid (add_valid),
        .sum       (sum),
        .cout      (cout),
        .sum_valid (sum_valid),
        .seg       (seg),
        .dp        (dp),
        .control   (control)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int checks = 0;
    int errors = 0;

    // Model: edges since reset release, registered sum, and the snapshot for the current slot.
    int          cyc;
    logic [15:0] m_sum;
    logic        m_cout, m_valid;
    logic [15:0] snap_sum;
    logic        snap_cout;
    int          digit;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [6:0] exp_seg();
        logic [3:0] nib;
        nib = 4'((snap_sum >> (4 * digit)) & 16'hF);
`ifdef LEADING_ZERO_BLANK_EN
        if (digit > 0 && (snap_sum >> (4 * digit)) == 16'h0) return 7'h7F;
`endif
        return HEX[nib];
    endfunction

    task automatic check_reset_vals();
        chk("rst_sum", 32'(sum), 32'h0);
        chk("rst_cout", 32'(cout), 32'h0);
        chk("rst_valid", 32'(sum_valid), 32'h0);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_control", 32'(control), 32'hF);
    endtask

    task automatic step(input logic av, input logic [15:0] ai, input logic [15:0] bi,
                        input logic ci);
        logic [16:0] full;
        logic [3:0]  exp_ctrl;
        a = ai; b = bi; cin = ci; add_valid = av;
        if (cyc % RDIV == 0) begin
            snap_sum  = m_sum;
            snap_cout = m_cout;
            digit     = (cyc / RDIV) % DIGITS;
        end
        if (av) begin
            full   = {1'b0, ai} + {1'b0, bi} + 17'(ci);
            m_sum  = full[15:0];
            m_cout = full[16];
        end
        m_valid = av;
        @(posedge clk);
        #1;
        cyc++;
        add_valid = 1'b0;
        exp_ctrl  = ~(4'b0001 << digit);
        chk("sum", 32'(sum), 32'(m_sum));
        chk("cout", 32'(cout), 32'(m_cout));
        chk("sum_valid", 32'(sum_valid), 32'(m_valid));
        chk("control", 32'(control), 32'(exp_ctrl));
        chk("seg", 32'(seg), 32'(exp_seg()));
        chk("dp", 32'(dp), 32'(!(digit == DIGITS - 1 && snap_cout)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic model_reset();
        cyc = 0; m_sum = '0; m_cout = 1'b0; m_valid = 1'b0;
        snap_sum = '0; snap_cout = 1'b0; digit = 0;
    endtask

    initial begin
        rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; add_valid = 1'b0;
        model_reset();
        #12;
        check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;

        // First slot after release must enable digit 0.
        idle(1);
        chk("first_slot_ctrl", 32'(control), 32'hE);

        // 1234 + 0001, then let every digit scan through twice.
        step(1'b1, 16'h1234, 16'h0001, 1'b0);
        chk("sum_1235", 32'(sum), 32'h1235);
        idle(32);

        // Overflow to zero with carry shown on the top digit's dp.
        step(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        idle(32);

        // Carry-in and back-to-back strobes: last one wins.
        step(1'b1, 16'h00F0, 16'h000F, 1'b1);
        step(1'b1, 16'h0040, 16'h0002, 1'b0);
        idle(20);
        step(1'b1, 16'h0000, 16'h0000, 1'b0);
        idle(20);

        // Strobe on the first edge of slot 1: that slot keeps the old nibble.
        while (cyc % (RDIV * DIGITS) != RDIV) step(1'b0, 16'h0, 16'h0, 1'b0);
        step(1'b1, 16'h0A50, 16'h0000, 1'b0);
        idle(20);

        // Asynchronous reset between edges, mid-slot.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(1);
        chk("restart_ctrl", 32'(control), 32'hE);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, 16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
